// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - synchronised group debouncer for the switch bus; optional commit counter under SW_DEBOUNCE_CHG_CNT_EN
module sw_debounce #(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 19
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW,
  output logic             sw_chg,
`ifdef SW_DEBOUNCE_CHG_CNT_EN
  output logic [7:0]       chg_cnt,
`endif
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] QUAL = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;

  // Two-flop synchroniser; s2 is the only value the FSM ever looks at.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SW_RAW;
      s2 <= s1;
    end
  end

  // Qualify a whole-bus candidate; any bit change restarts the hold count so
  // multi-bit codes commit atomically.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cand   <= '0;
      cnt    <= '0;
      SW     <= '0;
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= 1'b0;
      case (state)
        IDLE: begin
          if (s2 != SW) begin
            cand  <= s2;
            cnt   <= '0;
            state <= QUAL;
          end
        end
        default: begin
          if (s2 == SW) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            SW     <= cand;
            sw_chg <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = state[0];

`ifdef SW_DEBOUNCE_CHG_CNT_EN
  // Count commits for bounce characterisation; wraps naturally at 8 bits.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      chg_cnt <= 8'd0;
    end else if (sw_chg) begin
      chg_cnt <= chg_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce with CNT_MAX=8
module tb_sw_debounce;

  localparam int CM  = 8;
  localparam int LAT = 2 + 1 + CM;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic [3:0] SW_RAW;
  logic [3:0] SW;
  logic       sw_chg;
  logic       busy;
`ifdef SW_DEBOUNCE_CHG_CNT_EN
  logic [7:0] chg_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] prev_sw  = 4'b0000;
  logic       prev_chg = 1'b0;

  sw_debounce #(.WIDTH(4), .CNT_MAX(CM), .CNT_W(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .SW_RAW   (SW_RAW),
    .SW       (SW),
    .sw_chg   (sw_chg),
`ifdef SW_DEBOUNCE_CHG_CNT_EN
    .chg_cnt  (chg_cnt),
`endif
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_commit(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.at   = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    check("drain", sb.size(), 0);
    tick(1);
  endtask

  // Monitor: every strobe must match the next scoreboard entry in code and cycle.
  always @(negedge CLOCK_50) begin
    if (RST_N === 1'b1) begin
      if (sw_chg === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_chg", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("chg_code", SW, mon_e.code);
          check("chg_cycle", cyc, mon_e.at);
        end
        check("chg_back_to_back", prev_chg, 0);
      end else if (SW !== prev_sw) begin
        check("sw_without_chg", SW, prev_sw);
      end
    end
    prev_sw  <= SW;
    prev_chg <= sw_chg;
  end

  initial begin
    RST_N  = 1'b1;
    SW_RAW = 4'b1010;
    #2 RST_N = 1'b0;

    // 1: reset with 1010 applied, then release
    tick(3);
    check("rst_sw", SW, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_chg", sw_chg, 0);
    RST_N = 1'b1;
    expect_commit(4'b1010);
    tick(LAT - 1);
    check("t1_before_commit", SW, 4'b0000);
    drain();
    check("t1_sw", SW, 4'b1010);

    // return to zero before the glitch test
    SW_RAW = 4'b0000;
    expect_commit(4'b0000);
    drain();

    // 2: 4-cycle glitch must not commit
    SW_RAW = 4'b0001;
    tick(4);
    check("t2_busy_high", busy, 1);
    SW_RAW = 4'b0000;
    tick(6);
    check("t2_busy_low", busy, 0);
    check("t2_sw", SW, 4'b0000);

    // 3: bouncing between 0011 and 0001, then settle on 0011
    for (int r = 0; r < 2; r++) begin
      SW_RAW = 4'b0011;
      tick(3);
      SW_RAW = 4'b0001;
      tick(3);
    end
    check("t3_busy", busy, 1);
    check("t3_sw_held", SW, 4'b0000);
    SW_RAW = 4'b0011;
    expect_commit(4'b0011);
    drain();
    check("t3_sw", SW, 4'b0011);

    // 4: 0000 -> 0100 -> 1000 with 20-cycle holds
    SW_RAW = 4'b0000;
    expect_commit(4'b0000);
    drain();
    SW_RAW = 4'b0100;
    expect_commit(4'b0100);
    tick(20);
    SW_RAW = 4'b1000;
    expect_commit(4'b1000);
    tick(20);
    drain();
    check("t4_sw", SW, 4'b1000);

    // 5: reset at cnt=5 while qualifying 1100
    SW_RAW = 4'b1100;
    tick(8);
    check("t5_busy", busy, 1);
    RST_N = 1'b0;
    #1;
    check("t5_rst_sw", SW, 4'b0000);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_chg", sw_chg, 0);
    tick(2);
    RST_N = 1'b1;
    expect_commit(4'b1100);
    drain();
    check("t5_sw", SW, 4'b1100);

`ifdef SW_DEBOUNCE_CHG_CNT_EN
    // 6: 257 commits since reset wraps the counter back to 1
    check("t6_cnt_first", chg_cnt, 1);
    for (int k = 0; k < 256; k++) begin
      SW_RAW = (k % 2 == 0) ? 4'b0000 : 4'b1100;
      expect_commit(SW_RAW);
      drain();
    end
    check("t6_cnt_wrap", chg_cnt, 1);
`endif

    tick(5);
    check("final_queue", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
